// File: rtl/prog_load_ctrl_if.sv
// Byte-stream loader bus: serial program bytes in, program-memory write port out.
interface prog_load_ctrl_if #(
  parameter int ADD_WIDTH = 8,
  parameter int WIDTH     = 32
);
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 mem_wen;
  logic [ADD_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]     mem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// Program loader: takes a word-count header and little-endian instruction bytes,
// writes whole words to program memory, then releases the CPU.
//
// state | meaning
// IDLE  | waiting for load_req, CPU held
// HDR   | waiting for the word-count byte
// LOAD  | assembling the four bytes of a word
// WRITE | one-cycle memory write strobe
// RUN   | program loaded, CPU released
// ERR   | load aborted by inter-byte timeout
module prog_load_ctrl #(
  parameter int ADD_WIDTH = 8,
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  prog_load_ctrl_if.master  bus,
  output logic              cpu_run,
  output logic              busy,
  output logic              error
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR, LOAD, WRITE, RUN, ERR} state_t;

  state_t               state, state_next;
  logic [ADD_WIDTH-1:0] word_idx, last_idx;
  logic [1:0]           byte_idx;
  logic [TW-1:0]        to_cnt;
  logic [WIDTH-1:0]     asm_word, next_word;
  logic                 accept, timeout_hit, hdr_entry;

  assign bus.byte_ready = (state == HDR) || (state == LOAD);
  assign bus.mem_wen    = (state == WRITE);
  assign cpu_run        = (state == RUN);
  assign busy           = (state == HDR) || (state == LOAD) || (state == WRITE);
  assign error          = (state == ERR);

  assign accept      = bus.byte_ready && bus.byte_valid;
  // an accepted byte on the would-be timeout cycle wins over the timeout
  assign timeout_hit = bus.byte_ready && !accept && (to_cnt >= TW'(TIMEOUT - 1));
  assign hdr_entry   = (state_next == HDR) && (state != HDR);

  always_comb begin
    next_word = asm_word;
    next_word[{byte_idx, 3'b000} +: 8] = bus.byte_data;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (load_req) state_next = HDR;
      HDR: begin
        if (accept)           state_next = LOAD;
        else if (timeout_hit) state_next = ERR;
      end
      LOAD: begin
        if (accept && byte_idx == 2'd3) state_next = WRITE;
        else if (timeout_hit)           state_next = ERR;
      end
      WRITE: state_next = (word_idx == last_idx) ? RUN : LOAD;
      RUN:   if (load_req) state_next = HDR;
      ERR:   if (load_req) state_next = HDR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      word_idx      <= '0;
      last_idx      <= '0;
      byte_idx      <= '0;
      to_cnt        <= '0;
      asm_word      <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state <= state_next;

      if (hdr_entry) begin
        to_cnt   <= '0;
        word_idx <= '0;
        byte_idx <= '0;
        asm_word <= '0;
      end else if (bus.byte_ready) begin
        if (accept)                       to_cnt <= '0;
        else if (to_cnt != TW'(TIMEOUT))  to_cnt <= to_cnt + 1'b1;
      end

      // header value 0 wraps to all-ones, i.e. a full 2^ADD_WIDTH word load
      if (state == HDR && accept) last_idx <= ADD_WIDTH'(bus.byte_data) - 1'b1;

      if (state == LOAD && accept) begin
        asm_word <= next_word;
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) begin
          bus.mem_addr  <= word_idx;
          bus.mem_wdata <= next_word;
        end
      end

      if (state == WRITE && state_next == LOAD) word_idx <= word_idx + 1'b1;
    end
  end
endmodule
